// File: rtl/mcore_mem_arb_2port.sv
// mcore_mem_arb_2port
// Two-requester round-robin arbiter in front of a single-ported test memory.
// Requests pass through combinationally; the requester ID of every issued
// request is queued in a small in-flight FIFO so that the in-order memory
// responses can be steered back to the requester that issued them.
// Optional build macro: MCORE_MEM_ARB_DOMAIN_DRAIN_EN. When it is defined,
// a request whose security level differs from the last issued one must wait
// until the memory pipeline has fully drained.
module mcore_mem_arb_2port #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_max_inflight = 4,
    localparam int c_req_cnbits  = 3 + p_opaque_nbits + p_addr_nbits + $clog2(p_data_nbits / 8),
    localparam int c_resp_cnbits = 3 + p_opaque_nbits + $clog2(p_data_nbits / 8),
    localparam int c_cnt_nbits   = $clog2(p_max_inflight) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sec_level0,
    input  logic                     sec_level1,
    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic [c_req_cnbits-1:0]  req0_control,
    input  logic [p_data_nbits-1:0]  req0_data,
    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic [c_req_cnbits-1:0]  req1_control,
    input  logic [p_data_nbits-1:0]  req1_data,
    output logic                     resp0_val,
    input  logic                     resp0_rdy,
    output logic [c_resp_cnbits-1:0] resp0_control,
    output logic [p_data_nbits-1:0]  resp0_data,
    output logic                     resp1_val,
    input  logic                     resp1_rdy,
    output logic [c_resp_cnbits-1:0] resp1_control,
    output logic [p_data_nbits-1:0]  resp1_data,
    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [c_req_cnbits-1:0]  memreq_control,
    output logic [p_data_nbits-1:0]  memreq_data,
    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [c_resp_cnbits-1:0] memresp_control,
    input  logic [p_data_nbits-1:0]  memresp_data,
    output logic                     mem_sec_level,
    output logic [c_cnt_nbits-1:0]   inflight_cnt
);

    localparam int c_ptr_nbits = $clog2(p_max_inflight);
    localparam logic [c_cnt_nbits-1:0] c_cnt_full = c_cnt_nbits'(p_max_inflight);

    logic [p_max_inflight-1:0] id_mem;
    logic [c_ptr_nbits-1:0]    wr_ptr;
    logic [c_ptr_nbits-1:0]    rd_ptr;
    logic [c_cnt_nbits-1:0]    count;
    logic                      prio;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      can_issue;
    logic                      lvl_ok0;
    logic                      lvl_ok1;
    logic                      elig0;
    logic                      elig1;
    logic                      grant;
    logic                      head;
    logic                      push;
    logic                      pop;

`ifdef MCORE_MEM_ARB_DOMAIN_DRAIN_EN
    logic last_lvl;

    // Remember the security level of the most recently issued request
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_lvl <= 1'b0;
        end else if (push) begin
            last_lvl <= mem_sec_level;
        end
    end

    // A level switch is only allowed once nothing is left in flight
    always_comb begin
        lvl_ok0 = (sec_level0 == last_lvl) || (count == '0);
        lvl_ok1 = (sec_level1 == last_lvl) || (count == '0);
    end
`else
    // Without domain draining every requester is always level-compatible
    always_comb begin
        lvl_ok0 = 1'b1;
        lvl_ok1 = 1'b1;
    end
`endif

    // FIFO status; a full FIFO blocks issue even if a pop happens this cycle
    always_comb begin
        fifo_full    = (count == c_cnt_full);
        fifo_empty   = (count == '0);
        inflight_cnt = count;
        can_issue    = reset && !fifo_full;
    end

    // Round-robin grant and combinational request mux toward memory
    always_comb begin
        elig0 = req0_val && lvl_ok0;
        elig1 = req1_val && lvl_ok1;
        if (elig0 && elig1) begin
            grant = prio;
        end else begin
            grant = elig1;
        end
        memreq_val     = can_issue && (elig0 || elig1);
        memreq_control = grant ? req1_control : req0_control;
        memreq_data    = grant ? req1_data : req0_data;
        mem_sec_level  = grant ? sec_level1 : sec_level0;
        req0_rdy       = can_issue && lvl_ok0 && !grant && memreq_rdy;
        req1_rdy       = can_issue && lvl_ok1 && grant && memreq_rdy;
        push           = memreq_val && memreq_rdy;
    end

    // Steer the in-order memory response to the requester at the FIFO head
    always_comb begin
        head            = id_mem[rd_ptr];
        resp0_val       = reset && memresp_val && !fifo_empty && !head;
        resp1_val       = reset && memresp_val && !fifo_empty && head;
        resp0_control   = memresp_control;
        resp0_data      = memresp_data;
        resp1_control   = memresp_control;
        resp1_data      = memresp_data;
        memresp_rdy     = reset && !fifo_empty && (head ? resp1_rdy : resp0_rdy);
        pop             = memresp_val && memresp_rdy;
    end

    // In-flight ID FIFO and round-robin pointer state
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prio   <= 1'b0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= grant;
                wr_ptr         <= wr_ptr + c_ptr_nbits'(1);
                prio           <= ~grant;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + c_ptr_nbits'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + c_cnt_nbits'(1);
                2'b01:   count <= count - c_cnt_nbits'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mcore_mem_arb_2port.sv
// tb_mcore_mem_arb_2port
// Self-checking bench: randomized requesters and a memory model, with a
// queue-based reference model of outstanding requests, plus directed
// scenarios whose results are pinned with hand-computed constants.
// Honours MCORE_MEM_ARB_DOMAIN_DRAIN_EN the same way as the design.
module tb_mcore_mem_arb_2port;

    localparam int O     = 8;
    localparam int A     = 32;
    localparam int D     = 32;
    localparam int DEPTH = 4;
    localparam int CREQ  = 3 + O + A + $clog2(D / 8);
    localparam int CRESP = 3 + O + $clog2(D / 8);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             sec_level0, sec_level1;
    logic             req0_val, req0_rdy, req1_val, req1_rdy;
    logic [CREQ-1:0]  req0_control, req1_control, memreq_control;
    logic [D-1:0]     req0_data, req1_data, memreq_data;
    logic             resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [CRESP-1:0] resp0_control, resp1_control, memresp_control;
    logic [D-1:0]     resp0_data, resp1_data, memresp_data;
    logic             memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic             mem_sec_level;
    logic [CW-1:0]    inflight_cnt;

    mcore_mem_arb_2port #(
        .p_opaque_nbits (O),
        .p_addr_nbits   (A),
        .p_data_nbits   (D),
        .p_max_inflight (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sec_level0      (sec_level0),
        .sec_level1      (sec_level1),
        .req0_val        (req0_val),
        .req0_rdy        (req0_rdy),
        .req0_control    (req0_control),
        .req0_data       (req0_data),
        .req1_val        (req1_val),
        .req1_rdy        (req1_rdy),
        .req1_control    (req1_control),
        .req1_data       (req1_data),
        .resp0_val       (resp0_val),
        .resp0_rdy       (resp0_rdy),
        .resp0_control   (resp0_control),
        .resp0_data      (resp0_data),
        .resp1_val       (resp1_val),
        .resp1_rdy       (resp1_rdy),
        .resp1_control   (resp1_control),
        .resp1_data      (resp1_data),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memreq_control  (memreq_control),
        .memreq_data     (memreq_data),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .memresp_control (memresp_control),
        .memresp_data    (memresp_data),
        .mem_sec_level   (mem_sec_level),
        .inflight_cnt    (inflight_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state: outstanding requester IDs, memory-side pending
    // requests, and per-requester queues of data awaiting a response.
    bit              id_q[$];
    logic [CREQ-1:0] mp_ctrl[$];
    logic [D-1:0]    mp_data[$];
    logic [D-1:0]    sent_q0[$];
    logic [D-1:0]    sent_q1[$];
    bit              m_ptr;
    bit              m_last;
    bit              issue_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs: percentage probabilities per cycle
    int k_v0, k_v1, k_mrdy, k_mresp, k_r0, k_r1;
    bit k_sec_rand;

    function automatic bit roll(int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic logic [15:0] packLog();
        logic [15:0] p = '0;
        for (int i = 0; i < issue_log.size() && i < 16; i++) p[i] = issue_log[i];
        return p;
    endfunction

    task automatic checkValue(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        logic [63:0]     r;
        logic [CREQ-1:0] c;
        r = {$urandom, $urandom};
        req0_val     = roll(k_v0);
        req1_val     = roll(k_v1);
        req0_control = r[CREQ-1:0];
        req0_data    = $urandom;
        r = {$urandom, $urandom};
        req1_control = r[CREQ-1:0];
        req1_data    = $urandom;
        memreq_rdy   = roll(k_mrdy);
        resp0_rdy    = roll(k_r0);
        resp1_rdy    = roll(k_r1);
        if (k_sec_rand) begin
            sec_level0 = r[60];
            sec_level1 = r[61];
        end
        if (mp_ctrl.size() > 0 && roll(k_mresp)) begin
            c               = mp_ctrl[0];
            memresp_val     = 1'b1;
            memresp_control = c[CRESP-1:0] ^ 13'h0A5;
            memresp_data    = mp_data[0] ^ 32'hDEAD_BEEF;
        end else begin
            memresp_val     = 1'b0;
            memresp_control = r[CRESP+2:3];
            memresp_data    = $urandom;
        end
    endtask

    task automatic checkOutput();
        bit              ok0, ok1, e0, e1, g, full, mval, hd, mrr, pushm, popm;
        int              sz;
        logic [CREQ-1:0] c;
        logic [D-1:0]    expd;
        checkValue("val_rdy_not_x",
                   64'($isunknown({req0_rdy, req1_rdy, resp0_val, resp1_val, memreq_val, memresp_rdy})), 64'd0);
        if (!reset) begin
            checkValue("val_rdy_in_reset",
                       64'({req0_rdy, req1_rdy, resp0_val, resp1_val, memreq_val, memresp_rdy}), 64'd0);
            id_q.delete(); mp_ctrl.delete(); mp_data.delete();
            sent_q0.delete(); sent_q1.delete();
            m_ptr  = 1'b0;
            m_last = 1'b0;
            return;
        end
        sz   = id_q.size();
        full = (sz == DEPTH);
        ok0  = 1'b1;
        ok1  = 1'b1;
`ifdef MCORE_MEM_ARB_DOMAIN_DRAIN_EN
        ok0 = (sec_level0 == m_last) || (sz == 0);
        ok1 = (sec_level1 == m_last) || (sz == 0);
`endif
        e0   = req0_val && ok0;
        e1   = req1_val && ok1;
        g    = (e0 && e1) ? m_ptr : e1;
        mval = !full && (e0 || e1);
        checkValue("memreq_val", 64'(memreq_val), 64'(mval));
        checkValue("req0_rdy", 64'(req0_rdy), 64'(!full && ok0 && !g && memreq_rdy));
        checkValue("req1_rdy", 64'(req1_rdy), 64'(!full && ok1 && g && memreq_rdy));
        checkValue("mem_sec_level", 64'(mem_sec_level), 64'(g ? sec_level1 : sec_level0));
        checkValue("inflight_cnt", 64'(inflight_cnt), 64'(sz));
        if (mval) begin
            checkValue("memreq_control", 64'(memreq_control), 64'(g ? req1_control : req0_control));
            checkValue("memreq_data", 64'(memreq_data), 64'(g ? req1_data : req0_data));
        end
        hd  = (sz > 0) ? id_q[0] : 1'b0;
        mrr = (sz > 0) && (hd ? resp1_rdy : resp0_rdy);
        checkValue("resp0_val", 64'(resp0_val), 64'(memresp_val && sz > 0 && !hd));
        checkValue("resp1_val", 64'(resp1_val), 64'(memresp_val && sz > 0 && hd));
        checkValue("memresp_rdy", 64'(memresp_rdy), 64'(mrr));
        if (memresp_val) checkValue("resp_while_empty", 64'(inflight_cnt != 0), 64'd1);
        pushm = mval && memreq_rdy;
        popm  = memresp_val && mrr;
        if (popm) begin
            c = mp_ctrl[0];
            if (hd) begin
                if (sent_q1.size() == 0) checkValue("resp1_scoreboard", 64'd0, 64'd1);
                else begin
                    expd = sent_q1.pop_front() ^ 32'hDEAD_BEEF;
                    checkValue("resp1_data", 64'(resp1_data), 64'(expd));
                    checkValue("resp1_control", 64'(resp1_control), 64'(c[CRESP-1:0] ^ 13'h0A5));
                end
            end else begin
                if (sent_q0.size() == 0) checkValue("resp0_scoreboard", 64'd0, 64'd1);
                else begin
                    expd = sent_q0.pop_front() ^ 32'hDEAD_BEEF;
                    checkValue("resp0_data", 64'(resp0_data), 64'(expd));
                    checkValue("resp0_control", 64'(resp0_control), 64'(c[CRESP-1:0] ^ 13'h0A5));
                end
            end
            void'(id_q.pop_front());
            void'(mp_ctrl.pop_front());
            void'(mp_data.pop_front());
        end
        if (pushm) begin
            id_q.push_back(g);
            issue_log.push_back(g);
            m_ptr  = !g;
            m_last = g ? sec_level1 : sec_level0;
            mp_ctrl.push_back(g ? req1_control : req0_control);
            mp_data.push_back(g ? req1_data : req0_data);
            if (g) sent_q1.push_back(req1_data);
            else   sent_q0.push_back(req0_data);
        end
    endtask

    // One cycle: drive just after the edge, compare mid-cycle, then advance
    task automatic runCycles(int n);
        repeat (n) begin
            applyStimulus();
            #3;
            checkOutput();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setKnobs(int v0, int v1, int mrdy, int mresp, int r0, int r1);
        k_v0 = v0; k_v1 = v1; k_mrdy = mrdy; k_mresp = mresp; k_r0 = r0; k_r1 = r1;
    endtask

    initial begin
        reset = 1'b0;
        sec_level0 = 1'b0; sec_level1 = 1'b0;
        req0_val = 1'b0; req1_val = 1'b0; req0_control = '0; req1_control = '0;
        req0_data = '0; req1_data = '0; memreq_rdy = 1'b0;
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        memresp_val = 1'b0; memresp_control = '0; memresp_data = '0;
        k_sec_rand = 1'b0;
        setKnobs(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        runCycles(2);
        reset = 1'b1;
        checkValue("reset_inflight", 64'(inflight_cnt), 64'd0);

        $display("[TB] alternating grants with both requesters busy");
        setKnobs(100, 100, 100, 100, 100, 100);
        issue_log.delete();
        runCycles(8);
        checkValue("alt_grant_count", 64'(issue_log.size()), 64'd8);
        checkValue("alt_grant_order", 64'(packLog()), 64'h00AA);

        $display("[TB] only requester 1 valid");
        setKnobs(0, 100, 100, 100, 100, 100);
        issue_log.delete();
        runCycles(5);
        checkValue("req1_only_order", 64'(packLog()), 64'h001F);

        $display("[TB] fill the in-flight FIFO");
        setKnobs(0, 0, 100, 100, 100, 100);
        runCycles(3);
        checkValue("drained_inflight", 64'(inflight_cnt), 64'd0);
        setKnobs(100, 100, 100, 0, 100, 100);
        issue_log.delete();
        runCycles(6);
        checkValue("full_issue_count", 64'(issue_log.size()), 64'd4);
        checkValue("full_inflight", 64'(inflight_cnt), 64'd4);
        checkValue("full_memreq_val", 64'(memreq_val), 64'd0);
        k_mresp = 100;
        runCycles(1);
        checkValue("no_issue_while_full", 64'(issue_log.size()), 64'd4);
        k_mresp = 0;
        runCycles(3);
        checkValue("one_more_issue", 64'(issue_log.size()), 64'd5);
        checkValue("refull_inflight", 64'(inflight_cnt), 64'd4);

        $display("[TB] response held off by requester 1");
        setKnobs(0, 0, 100, 100, 100, 100);
        runCycles(6);
        setKnobs(0, 100, 100, 0, 100, 100);
        runCycles(1);
        setKnobs(0, 0, 100, 100, 100, 0);
        runCycles(3);
        checkValue("held_resp_inflight", 64'(inflight_cnt), 64'd1);
        k_r1 = 100;
        runCycles(1);
        checkValue("released_resp_inflight", 64'(inflight_cnt), 64'd0);

        $display("[TB] reset with requests in flight");
        setKnobs(100, 100, 100, 0, 100, 100);
        runCycles(3);
        checkValue("pre_reset_inflight", 64'(inflight_cnt), 64'd3);
        reset = 1'b0;
        runCycles(1);
        checkValue("post_reset_inflight", 64'(inflight_cnt), 64'd0);
        checkValue("post_reset_memreq_val", 64'(memreq_val), 64'd0);
        reset = 1'b1;
        issue_log.delete();
        runCycles(1);
        checkValue("first_tie_after_reset", 64'(packLog()), 64'h0000);
        checkValue("first_tie_issued", 64'(issue_log.size()), 64'd1);

`ifdef MCORE_MEM_ARB_DOMAIN_DRAIN_EN
        $display("[TB] domain drain between security levels");
        reset = 1'b0;
        setKnobs(0, 0, 100, 0, 100, 100);
        runCycles(1);
        reset = 1'b1;
        sec_level0 = 1'b0;
        sec_level1 = 1'b1;
        issue_log.delete();
        setKnobs(100, 0, 100, 0, 100, 100);
        runCycles(2);
        setKnobs(0, 100, 100, 0, 100, 100);
        runCycles(3);
        checkValue("drain_held", 64'(issue_log.size()), 64'd2);
        k_mresp = 100;
        runCycles(3);
        checkValue("drain_granted", 64'(packLog()), 64'h0004);
        checkValue("drain_level", 64'(mem_sec_level), 64'd1);
`endif

        $display("[TB] randomized traffic");
        k_sec_rand = 1'b1;
        for (int seg = 0; seg < 10; seg++) begin
            setKnobs(int'($urandom_range(100)), int'($urandom_range(100)), int'($urandom_range(20, 100)),
                     int'($urandom_range(10, 100)), int'($urandom_range(20, 100)), int'($urandom_range(20, 100)));
            if (seg == 5) begin
                reset = 1'b0;
                runCycles(2);
                reset = 1'b1;
            end
            runCycles(200);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
